dmem_responder: RTL

Multi-cycle data-memory responder for the 64-bit RISC-V core. It is the memory-side end of the core's load/store port: it accepts one load or store request at a time through a valid/ready handshake and waits a programmable number of cycles. It then returns a single-cycle response carrying read data or an error flag. It replaces the zero-latency combinational data memory so the core's stall path can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 51 +++++
 rtl/dmem_byte_array.sv | 46 ++++
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and constants for the data-memory responder slice.
//   - state_t : responder FSM states (IDLE / WAIT / RESP)
//   - size_t  : access size encodings (SZ_B / SZ_H / SZ_W / SZ_D)
//   - ADDR_W / DATA_W : request address and data widths
//   - helpers turning an access size into byte count, lane mask and
//     alignment mask
package dmem_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_nbytes(input size_t size);
    return 4'd1 << size;
  endfunction

  // Byte lanes (relative to the access address) covered by the access.
  function automatic logic [7:0] size_lane_mask(input size_t size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_align_mask(input size_t size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array
// Byte-addressable storage behind the data-memory responder.
// Ports:
//   clk       in   rising-edge clock
//   we        in   write enable, bytes are written on the rising edge
//   addr      in   byte address (already reduced to the array index width)
//   lane_mask in   8-bit mask, bit i enables the byte at addr+i
//   wdata     in   64-bit little-endian write data, LSB-aligned
//   rdata     out  combinational 64-bit little-endian read starting at addr
// Storage is not reset; it starts out all zero.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [7:0]        lane_mask,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  // Index arithmetic wraps modulo the (power-of-two) depth; the responder
  // never commits an access that would actually wrap.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (lane_mask[i]) begin
          mem[addr + IDX_W'(i)] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + IDX_W'(i)];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder for the 64-bit core's load/store port.
// Accepts one request at a time over valid/ready, waits LATENCY cycles and
// returns a single-cycle response with load data or an error flag.
// Parameters:
//   DEPTH_BYTES  storage size in bytes (power of two, >= 8)
//   LATENCY      cycles from acceptance to response (1..15)
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  responder can accept this cycle (registered)
//   req_write   in   1 = store, 0 = load
//   req_addr    in   64-bit byte address
//   req_wdata   in   64-bit store data, little-endian, LSB-aligned
//   req_size    in   access size (only with DMEM_SIZE_EN)
//   resp_valid  out  one-cycle response pulse
//   resp_rdata  out  zero-extended load data, 0 for stores and errors
//   resp_err    out  out-of-range or misaligned request
// Configuration macro: DMEM_SIZE_EN enables sub-dword accesses through
// req_size; without it every access is a dword.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_SIZE_EN
  input  logic [1:0]        req_size,
`endif
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          IDX_W         = $clog2(DEPTH_BYTES);
  localparam bit          DIRECT_COMMIT = (LATENCY == 1);
  localparam logic [3:0]  WAIT_LOAD     = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [64:0] DEPTH_EXT     = 65'(DEPTH_BYTES);

  state_t              state;
  logic [3:0]          count;
  logic                cap_write;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  size_t               cap_size;

  size_t               in_size;
  logic                accept;
  logic                enter_resp;

  logic                eff_write;
  logic [ADDR_W-1:0]   eff_addr;
  logic [DATA_W-1:0]   eff_wdata;
  size_t               eff_size;

  logic [64:0]         end_addr;
  logic                range_err;
  logic                align_err;
  logic                req_err;
  logic [7:0]          lane_mask;
  logic [DATA_W-1:0]   lane_bits;
  logic [DATA_W-1:0]   array_rdata;
  logic                mem_we;

`ifdef DMEM_SIZE_EN
  assign in_size = size_t'(req_size);
`else
  assign in_size = SZ_D;
`endif

  assign accept = (state == IDLE) && req_ready && req_valid;

  // With LATENCY=1 the commit edge is the acceptance edge itself, so the
  // request must come straight from the ports rather than the capture
  // registers, which only load on that same edge.
  assign enter_resp = (DIRECT_COMMIT && accept) ||
                      (!DIRECT_COMMIT && (state == WAIT) && (count == 4'd0));

  assign eff_write = DIRECT_COMMIT ? req_write : cap_write;
  assign eff_addr  = DIRECT_COMMIT ? req_addr  : cap_addr;
  assign eff_wdata = DIRECT_COMMIT ? req_wdata : cap_wdata;
  assign eff_size  = DIRECT_COMMIT ? in_size   : cap_size;

  // The end address is formed one bit wider so addresses near 2^64 cannot
  // wrap back into the legal range.
  assign end_addr  = {1'b0, eff_addr} + 65'(size_nbytes(eff_size));
  assign range_err = end_addr > DEPTH_EXT;
  assign align_err = |(eff_addr[2:0] & size_align_mask(eff_size));
  assign req_err   = range_err || align_err;

  assign lane_mask = size_lane_mask(eff_size);

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < 8; i++) begin
      lane_bits[8*i +: 8] = {8{lane_mask[i]}};
    end
  end

  // Reset has priority over the commit, so a store whose response would
  // coincide with reset is dropped without touching storage.
  assign mem_we = enter_resp && eff_write && !req_err && reset;

  dmem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk       (clk),
    .we        (mem_we),
    .addr      (eff_addr[IDX_W-1:0]),
    .lane_mask (lane_mask),
    .wdata     (eff_wdata),
    .rdata     (array_rdata)
  );

  // Responder FSM. All outputs are registered: response fields are loaded
  // on the edge that enters RESP and cleared on every other edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_size   <= SZ_D;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_size  <= in_size;
            req_ready <= 1'b0;
            if (DIRECT_COMMIT) begin
              state <= RESP;
            end else begin
              count <= WAIT_LOAD;
              state <= WAIT;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= req_err;
        if (!req_err && !eff_write) begin
          resp_rdata <= array_rdata & lane_bits;
        end
      end
    end
  end

endmodule
